// File: rtl/dmem_pkg.sv
// Shared decode constants, FSM state type and byte-enable helper for the data memory LSU.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  // Store lane mask; illegal sizes get no enables.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = 4'b0011 << lane;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Picks the addressed byte/halfword out of a loaded word and sign- or zero-extends it.
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    result  = 32'h0;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      F3_W:    result = word;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed RV32I data memory for the MEM stage: registered one-cycle responses,
// fault reporting for bad accesses, and a post-reset clear sequencer.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int INIT_CLEAR  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              clear_busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  state_t           state;
  logic [IDX_W-1:0] clear_ptr;

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             in_range;
  logic             fault;
  logic             accept;
  logic             wr_en;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [31:0]      load_val;

  assign idx      = req_addr[IDX_W+1:2];
  assign lane     = req_addr[1:0];
  assign in_range = (req_addr >> (IDX_W + 2)) == '0;

  always_comb begin
    fault = !in_range;
    case (req_funct3)
      F3_B:    fault = fault;
      F3_H:    fault = fault | lane[0];
      F3_W:    fault = fault | (lane != 2'b00);
      F3_BU:   fault = fault | req_we;
      F3_HU:   fault = fault | req_we | lane[0];
      default: fault = 1'b1;
    endcase
  end

  // A request transfers when req_valid && req_ready at a rising clk edge; the response
  // follows exactly one cycle later as a single rsp_valid pulse with no backpressure.
  assign accept = req_valid && req_ready;
  assign wr_en  = accept && req_we && !fault;
  assign be     = byte_en(req_funct3, lane);

  always_comb begin
    case (req_funct3)
      F3_B:    wdata_rep = {4{req_wdata[7:0]}};
      F3_H:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  dmem_load_extend u_load_extend (
    .word   (mem[idx]),
    .lane   (lane),
    .funct3 (req_funct3),
    .result (load_val)
  );

  // Storage has no reset; the clear sequencer zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clear_ptr] <= 32'h0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
      clear_busy <= (INIT_CLEAR != 0);
      clear_ptr  <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_fault  <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_fault <= accept && fault;
      rsp_rdata <= (accept && !req_we && !fault) ? load_val : 32'h0;
      case (state)
        ST_CLEAR: begin
          clear_ptr <= clear_ptr + 1'b1;
          if (clear_ptr == IDX_W'(DEPTH_WORDS - 1)) begin
            state      <= ST_IDLE;
            clear_busy <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Randomized and directed bench for data_memory_lsu against a byte-array reference model.
module tb_data_memory_lsu;

  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        clear_busy;

  data_memory_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .INIT_CLEAR(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .clear_busy (clear_busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  model_mem [BYTES];
  logic [32:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int access_size(input logic [2:0] f3, input logic we);
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      3'b100:  return we ? 0 : 1;
      3'b101:  return we ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  // Reference: returns {fault, rdata} and applies stores to the byte array.
  function automatic logic [32:0] model_access(input logic we, input logic [2:0] f3,
                                               input logic [31:0] addr, input logic [31:0] wd);
    int sz;
    logic [31:0] v;
    sz = access_size(f3, we);
    if (sz == 0 || (addr % sz) != 0 || addr >= BYTES) return {1'b1, 32'h0};
    v = 32'h0;
    if (we) begin
      for (int i = 0; i < sz; i++) model_mem[addr + i] = wd[8*i +: 8];
      return {1'b0, 32'h0};
    end
    for (int i = 0; i < sz; i++) v = v | (32'(model_mem[addr + i]) << (8 * i));
    if (f3[2] == 1'b0 && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return {1'b0, v};
  endfunction

  // Called at a negedge; returns at the next negedge with the response checked.
  task automatic step(input logic v, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input string tag);
    logic acc;
    logic [32:0] e;
    req_valid = v; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    acc = v && req_ready;
    if (acc) exp_q.push_back(model_access(we, f3, addr, wd));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_valid"}, {31'h0, rsp_valid}, {31'h0, acc});
    if (acc && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_fault"}, {31'h0, rsp_fault}, {31'h0, e[32]});
      check({tag, "_rdata"}, rsp_rdata, e[31:0]);
    end else begin
      check({tag, "_idle_rdata"}, rsp_rdata, 32'h0);
    end
  endtask

  task automatic reset_and_clear();
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_clear_busy", {31'h0, clear_busy}, 32'h1);
    check("rst_rdata", rsp_rdata, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;
    n = 0;
    while (clear_busy && n < 1000) begin
      if (req_ready) check("clear_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("clear_cycles", n, 32'd256);
    check("idle_ready", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    @(negedge clk);
    reset_and_clear();

    step(1, 0, 3'b010, 32'h3FC, 32'h0, "lw_3fc");
    step(1, 1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
    step(1, 0, 3'b010, 32'h10, 32'h0, "lw_10");
    step(1, 0, 3'b000, 32'h13, 32'h0, "lb_13");
    step(1, 0, 3'b100, 32'h12, 32'h0, "lbu_12");
    step(1, 0, 3'b001, 32'h12, 32'h0, "lh_12");
    step(1, 0, 3'b101, 32'h10, 32'h0, "lhu_10");
    step(1, 1, 3'b000, 32'h21, 32'h123456AA, "sb_21");
    step(1, 0, 3'b010, 32'h20, 32'h0, "lw_20a");
    step(1, 1, 3'b001, 32'h22, 32'h0000CAFE, "sh_22");
    step(1, 0, 3'b010, 32'h20, 32'h0, "lw_20b");
    step(1, 0, 3'b010, 32'h22, 32'h0, "lw_22_flt");
    step(1, 1, 3'b001, 32'h23, 32'hFFFF, "sh_23_flt");
    step(1, 0, 3'b010, 32'h20, 32'h0, "lw_20c");
    step(1, 0, 3'b010, 32'h400, 32'h0, "lw_400_flt");
    step(1, 0, 3'b011, 32'h20, 32'h0, "ld_f3_011");
    step(1, 1, 3'b011, 32'h20, 32'h0, "st_f3_011");
    step(1, 1, 3'b010, 32'h40, 32'h11223344, "sw_40");
    step(1, 0, 3'b010, 32'h40, 32'h0, "lw_40");
    step(0, 0, 3'b010, 32'h0, 32'h0, "bubble");

    for (int i = 0; i < 400; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3 & ~(32'(f3[1]) << 1) | (f3[0] ? 32'h0 : a & 32'h1);
      if ($urandom_range(0, 3) != 0) a = a & 32'h7F;
      if ($urandom_range(0, 19) == 0) a = a + BYTES;
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), f3, a, $urandom, "rand");
    end

    // Reset arrives while a load response is on the outputs.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_rsp_before", {31'h0, rsp_valid}, 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rsp_dropped", {31'h0, rsp_valid}, 32'h0);
    check("mid_clear_busy", {31'h0, clear_busy}, 32'h1);
    @(negedge clk);
    check("mid_rsp_stays", {31'h0, rsp_valid}, 32'h0);
    exp_q.delete();
    reset_and_clear();
    step(1, 0, 3'b010, 32'h40, 32'h0, "post_lw_40");
    step(1, 0, 3'b010, 32'h3FC, 32'h0, "post_lw_3fc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
